// File: rtl/tx_zero_insert.sv
// HDLC transmit serialiser: wraps bytes in flags, stuffs a 0 after STUFF_LIMIT ones,
// emits an abort pattern on request and idles the line high.
module tx_zero_insert #(
    parameter logic [7:0]  FLAG          = 8'h7E,
    parameter logic [7:0]  ABORT_PATTERN = 8'hFE,
    parameter int unsigned STUFF_LIMIT   = 5
) (
    input  logic       Clk,
    input  logic       Rst,
    input  logic       ValidFrame,
    input  logic       AbortFrame,
    input  logic [7:0] Data,
    output logic       Tx,
    output logic       NewByte,
    output logic       FlagActive,
    output logic       AbortedTrans
);

    typedef enum logic [2:0] {StIdle, StStart, StData, StEnd, StAbort} state_e;

    localparam logic [2:0] StuffLimit = 3'(STUFF_LIMIT);

    state_e     state_q, state_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [2:0] ones_q, ones_d;
    logic [7:0] shift_q, shift_d;
    logic       last_q, last_d;
    logic       tx_q, tx_d;
    logic       new_byte_q, new_byte_d;
    logic       flag_q, flag_d;
    logic       aborted_q, aborted_d;

    logic       data_bit;
    logic [2:0] ones_inc;
    logic       boundary;

    assign data_bit = shift_q[bit_cnt_q];
    assign ones_inc = ones_q + 3'd1;

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        ones_d     = ones_q;
        shift_d    = shift_q;
        last_d     = last_q;
        tx_d       = tx_q;
        new_byte_d = 1'b0;
        aborted_d  = 1'b0;
        boundary   = 1'b0;

        unique case (state_q)
            StIdle: begin
                tx_d      = 1'b1;
                bit_cnt_d = 3'd0;
                ones_d    = 3'd0;
                last_d    = 1'b0;
                if (ValidFrame) begin
                    state_d   = StStart;
                    tx_d      = FLAG[0];
                    bit_cnt_d = 3'd1;
                end
            end
            StStart: begin
                tx_d      = FLAG[bit_cnt_q];
                bit_cnt_d = bit_cnt_q + 3'd1;
                if (bit_cnt_q == 3'd7) begin
                    shift_d    = Data;
                    new_byte_d = 1'b1;
                    ones_d     = 3'd0;
                    bit_cnt_d  = 3'd0;
                    state_d    = StData;
                end
            end
            StData: begin
                if (ones_q == StuffLimit) begin
                    // Stuffed zero; a byte boundary deferred by it completes here.
                    tx_d   = 1'b0;
                    ones_d = 3'd0;
                    if (last_q) begin
                        last_d   = 1'b0;
                        boundary = 1'b1;
                    end
                end else begin
                    tx_d      = data_bit;
                    ones_d    = data_bit ? ones_inc : 3'd0;
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        if (data_bit && (ones_inc == StuffLimit)) begin
                            last_d = 1'b1;
                        end else begin
                            boundary = 1'b1;
                        end
                    end
                end
            end
            StEnd: begin
                if (last_q) begin
                    tx_d    = 1'b1;
                    last_d  = 1'b0;
                    state_d = StIdle;
                end else begin
                    tx_d      = FLAG[bit_cnt_q];
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        last_d = 1'b1;
                    end
                end
            end
            StAbort: begin
                tx_d      = ABORT_PATTERN[bit_cnt_q];
                bit_cnt_d = bit_cnt_q + 3'd1;
                if (bit_cnt_q == 3'd7) begin
                    aborted_d = 1'b1;
                    state_d   = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
                tx_d    = 1'b1;
            end
        endcase

        if (boundary) begin
            bit_cnt_d = 3'd0;
            if (ValidFrame) begin
                shift_d    = Data;
                new_byte_d = 1'b1;
            end else begin
                state_d = StEnd;
            end
        end

        if (AbortFrame && (state_q == StStart || state_q == StData || state_q == StEnd)) begin
            state_d    = StAbort;
            tx_d       = ABORT_PATTERN[0];
            bit_cnt_d  = 3'd1;
            ones_d     = 3'd0;
            last_d     = 1'b0;
            shift_d    = shift_q;
            new_byte_d = 1'b0;
        end

        flag_d = (state_d == StStart) || (state_d == StEnd);
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state_q    <= StIdle;
            bit_cnt_q  <= 3'd0;
            ones_q     <= 3'd0;
            shift_q    <= 8'h00;
            last_q     <= 1'b0;
            tx_q       <= 1'b1;
            new_byte_q <= 1'b0;
            flag_q     <= 1'b0;
            aborted_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            ones_q     <= ones_d;
            shift_q    <= shift_d;
            last_q     <= last_d;
            tx_q       <= tx_d;
            new_byte_q <= new_byte_d;
            flag_q     <= flag_d;
            aborted_q  <= aborted_d;
        end
    end

    assign Tx           = tx_q;
    assign NewByte      = new_byte_q;
    assign FlagActive   = flag_q;
    assign AbortedTrans = aborted_q;

endmodule
